// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer
//   Multi-cycle MUL/DIV unit that the control unit stalls on. A multiply runs
//   a radix-4 Booth recode, one digit per cycle. A divide runs a restoring
//   divide on operand magnitudes, one bit per cycle, followed by a sign-fix
//   cycle. Results are written to HI/LO on entry to DONE.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request pulse, sampled only in IDLE
//   op           0 = multiply, 1 = divide (sampled with start)
//   a, b         signed operands (sampled with start)
//   busy         high from the cycle after accept through DONE inclusive
//   done         single-cycle pulse; hi/lo valid in the same cycle
//   div_by_zero  valid with done; set only for a divide with b == 0
//   hi, lo       product high/low word, or remainder/quotient
module mul_div_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*W-1:0] acc_q, acc_d;       // Booth accumulator
  logic [2*W-1:0] mcand_q, mcand_d;   // sign-extended multiplicand, pre-shifted by 2i
  logic [W:0]     mplr_q, mplr_d;     // {b, 1'b0}; low 3 bits are the current digit
  logic [W-1:0]   rem_q, rem_d;       // partial remainder
  logic [W-1:0]   quo_q, quo_d;       // |dividend| shifting out, quotient shifting in
  logic [W-1:0]   dvsr_q, dvsr_d;     // |divisor|
  logic           negq_q, negq_d;     // quotient needs negation
  logic           negr_q, negr_d;     // remainder needs negation
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           dbz_q, dbz_d;

  logic           mul_last;
  logic           div_last;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] acc_sum;
  logic [W:0]     rem_shift;
  logic [W:0]     rem_diff;

  assign mul_last = (cnt_q == CW'(W/2 - 1));
  assign div_last = (cnt_q == CW'(W - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op)           state_d = S_MUL;
          else if (b == '0)  state_d = S_DONE;
          else               state_d = S_DIV;
        end
      end
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DIV:  if (div_last) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

  // Booth partial product for the current digit {b[2i+1], b[2i], b[2i-1]}
  always_comb begin
    unique case (mplr_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
  end

  // Restoring divide step: the trial subtract succeeds when no borrow appears
  // in the top bit; the shifted remainder never exceeds W+1 bits.
  assign rem_shift = {rem_q, quo_q[W-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};

  // Datapath next-state
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          mcand_d = {{W{a[W-1]}}, a};
          mplr_d  = {b, 1'b0};
          rem_d   = '0;
          quo_d   = a[W-1] ? -a : a;
          dvsr_d  = b[W-1] ? -b : b;
          negq_d  = a[W-1] ^ b[W-1];
          negr_d  = a[W-1];
          cnt_d   = '0;
          if (op && (b == '0)) begin
            hi_d  = a;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            dbz_d = 1'b0;
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        cnt_d   = cnt_q + CW'(1);
        if (mul_last) begin
          hi_d = acc_sum[2*W-1:W];
          lo_d = acc_sum[W-1:0];
        end
      end
      S_DIV: begin
        if (!rem_diff[W]) begin
          rem_d = rem_diff[W-1:0];
        end else begin
          rem_d = rem_shift[W-1:0];
        end
        quo_d = {quo_q[W-2:0], ~rem_diff[W]};
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        hi_d = negr_q ? -rem_q : rem_q;
        lo_d = negq_q ? -quo_q : quo_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer (DATA_WIDTH = 32).
module tb_mul_div_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  mul_div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: signed arithmetic on 64-bit integers.
  function automatic void model(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                output logic [W-1:0] eh, output logic [W-1:0] el,
                                output logic ed, output int elat);
    longint sa, sb, r;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    if (!op_i) begin
      r    = sa * sb;
      eh   = r[2*W-1:W];
      el   = r[W-1:0];
      ed   = 1'b0;
      elat = int'(W/2 + 1);
    end else if (b_i == '0) begin
      eh   = a_i;
      el   = '1;
      ed   = 1'b1;
      elat = 1;
    end else begin
      r    = sa / sb;
      el   = r[W-1:0];
      r    = sa % sb;
      eh   = r[W-1:0];
      ed   = 1'b0;
      elat = int'(W + 2);
    end
  endfunction

  // Issues one operation and waits (bounded) for done. lat_o is the count of
  // cycles from the accepting edge to done inclusive; 0 means it never came.
  task automatic run_op(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        output logic [W-1:0] hi_o, output logic [W-1:0] lo_o,
                        output logic dbz_o, output int lat_o, output int busy_o);
    hi_o = '0; lo_o = '0; dbz_o = 1'b0; lat_o = 0; busy_o = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0;
    op = 1'($urandom_range(1));
    a = $urandom;
    b = $urandom;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) busy_o++;
      if (done) begin
        hi_o = hi; lo_o = lo; dbz_o = div_by_zero; lat_o = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul_directed();
    logic [W-1:0] ta [3] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] tb [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] th [3] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0000_0000};
    logic [W-1:0] tl [3] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h0000_0001};
    logic [W-1:0] rh, rl;
    logic rd;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, ta[i], tb[i], rh, rl, rd, lat, bc);
      checks++;
      if (lat !== 17) begin
        errors++; $display("FAIL mul_latency[%0d]: got %0d, required 17", i, lat);
      end
      checks++;
      if (bc !== 17) begin
        errors++; $display("FAIL mul_busy_cycles[%0d]: got %0d, required 17", i, bc);
      end
      checks++;
      if ({rd, rh, rl} !== {1'b0, th[i], tl[i]}) begin
        errors++;
        $display("FAIL mul_result[%0d]: dbz=%b hi=%h lo=%h, required dbz=0 hi=%h lo=%h",
                 i, rd, rh, rl, th[i], tl[i]);
      end
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
          errors++; $display("FAIL done_pulse_width: busy=%b done=%b, required 0 0", busy, done);
        end
      end
    end
  endtask

  task automatic test_div_directed();
    logic [W-1:0] ta [2] = '{32'hFFFF_FFEF, 32'h8000_0000};
    logic [W-1:0] tb [2] = '{32'h0000_0005, 32'hFFFF_FFFF};
    logic [W-1:0] th [2] = '{32'hFFFF_FFFE, 32'h0000_0000};
    logic [W-1:0] tl [2] = '{32'hFFFF_FFFD, 32'h8000_0000};
    logic [W-1:0] rh, rl;
    logic rd;
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, ta[i], tb[i], rh, rl, rd, lat, bc);
      checks++;
      if (lat !== 34) begin
        errors++; $display("FAIL div_latency[%0d]: got %0d, required 34", i, lat);
      end
      checks++;
      if ({rd, rh, rl} !== {1'b0, th[i], tl[i]}) begin
        errors++;
        $display("FAIL div_result[%0d]: dbz=%b hi=%h lo=%h, required dbz=0 hi=%h lo=%h",
                 i, rd, rh, rl, th[i], tl[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [W-1:0] rh, rl;
    logic rd;
    int lat, bc;
    run_op(1'b1, 32'h0000_1234, 32'h0, rh, rl, rd, lat, bc);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL dbz_latency: got %0d, required 1", lat);
    end
    checks++;
    if ({rd, rh, rl} !== {1'b1, 32'h0000_1234, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL dbz_result: dbz=%b hi=%h lo=%h, required dbz=1 hi=00001234 lo=ffffffff",
               rd, rh, rl);
    end
    run_op(1'b0, 32'd2, 32'd3, rh, rl, rd, lat, bc);
    checks++;
    if ({rd, rh, rl} !== {1'b0, 32'h0, 32'h6}) begin
      errors++;
      $display("FAIL after_dbz_mul: dbz=%b hi=%h lo=%h, required dbz=0 hi=0 lo=6", rd, rh, rl);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, rh, rl, eh, el;
    logic rop, rd, ed;
    int lat, bc, elat;
    for (int n = 0; n < 40; n++) begin
      rop = 1'($urandom_range(1));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = '1;
        3: rb = W'($urandom_range(1, 9));
        default: ;
      endcase
      model(rop, ra, rb, eh, el, ed, elat);
      run_op(rop, ra, rb, rh, rl, rd, lat, bc);
      checks++;
      if (lat !== elat || bc !== elat) begin
        errors++;
        $display("FAIL rand_timing[%0d] op=%b a=%h b=%h: latency=%0d busy=%0d, required %0d",
                 n, rop, ra, rb, lat, bc, elat);
      end
      checks++;
      if ({rd, rh, rl} !== {ed, eh, el}) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%b a=%h b=%h: dbz=%b hi=%h lo=%h, required dbz=%b hi=%h lo=%h",
                 n, rop, ra, rb, rd, rh, rl, ed, eh, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] h1, l1, h2, l2, eh1, el1, eh2, el2;
    logic ed;
    int k1, k2, gap, elat;
    model(1'b0, 32'd1234, -32'sd56, eh1, el1, ed, elat);
    model(1'b1, -32'sd1000, 32'd33, eh2, el2, ed, elat);
    h1 = '0; l1 = '0; h2 = '0; l2 = '0;
    k1 = 0; k2 = 0; gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    start = 1'b1; op = 1'b0; a = 32'd1234; b = -32'sd56;
    @(posedge clk); #1;
    op = 1'b1; a = -32'sd1000; b = 32'd33;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (done) begin
        if (k1 == 0) begin
          k1 = k; h1 = hi; l1 = lo;
        end else begin
          k2 = k; h2 = hi; l2 = lo;
          break;
        end
      end else if (k1 != 0 && !busy) begin
        gap++;
      end
    end
    start = 1'b0;
    checks++;
    if (k1 !== 17 || k2 !== 52) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d and %0d, required 17 and 52", k1, k2);
    end
    checks++;
    if (gap !== 1) begin
      errors++; $display("FAIL b2b_idle_gap: got %0d, required 1", gap);
    end
    checks++;
    if ({h1, l1} !== {eh1, el1}) begin
      errors++; $display("FAIL b2b_mul_result: hi=%h lo=%h, required hi=%h lo=%h", h1, l1, eh1, el1);
    end
    checks++;
    if ({h2, l2} !== {eh2, el2}) begin
      errors++; $display("FAIL b2b_div_result: hi=%h lo=%h, required hi=%h lo=%h", h2, l2, eh2, el2);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [W-1:0] rh, rl;
    logic rd;
    int lat, bc, seen_done;
    run_op(1'b0, 32'd5, 32'd6, rh, rl, rd, lat, bc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    start = 1'b1; op = 1'b1; a = -32'sd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== '0) begin
      errors++;
      $display("FAIL reset_mid_div: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL aborted_activity: %0d busy/done cycles, required 0", seen_done);
    end
    run_op(1'b0, 32'd100, 32'd100, rh, rl, rd, lat, bc);
    checks++;
    if ({lat, rd, rh, rl} !== {32'sd17, 1'b0, 32'h0, 32'h0000_2710}) begin
      errors++;
      $display("FAIL post_reset_mul: latency=%0d dbz=%b hi=%h lo=%h, required 17 0 00000000 00002710",
               lat, rd, rh, rl);
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_div_by_zero();
    test_random();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Multi-cycle controller for the CPU's MUL and DIV instructions. It accepts a start request from the control unit and runs a radix-4 Booth multiply, one digit per cycle, or a signed restoring divide, one bit per cycle. Results go to HI/LO. It replaces the single-cycle combinational multiply path with a sequenced, handshaked unit that the control unit stalls on.

Parameters:
DATA_WIDTH, 32, operand width; must be even and ≥ 4; HI/LO are each DATA_WIDTH bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = multiply, 1 = divide; sampled with start
a  input  DATA_WIDTH  multiplicand / dividend, signed two's complement; sampled with start
b  input  DATA_WIDTH  multiplier / divisor, signed; sampled with start
busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive
done  output  1  single-cycle pulse; hi/lo valid in the same cycle
div_by_zero  output  1  valid with done; high when op=1 and b=0
hi  output  DATA_WIDTH  product[2W-1:W] or remainder
lo  output  DATA_WIDTH  product[W-1:0] or quotient

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; div_by_zero=0; hi=0; lo=0; all internal registers and counters cleared.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: start=1 at a rising edge latches a, b and op.
  - op=0 → MUL.
  - op=1 and b≠0 → DIV.
  - op=1 and b=0 → DONE directly.
- MUL:
  - 2W-bit accumulator; Booth digit i (i=0..W/2-1) is taken from {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Digit maps 000/111→0, 001/010→+a, 011→+2a, 100→-2a, 101/110→-a.
  - a is sign-extended to 2W before the shift by 2i.
  - One digit per cycle; exactly W/2 cycles, then DONE.
- DIV:
  - Operates on |a| and |b| as unsigned values.
  - Restoring algorithm, one quotient bit per cycle, MSB first; exactly W cycles, then FIX.
- FIX (1 cycle):
  - quotient negated if sign(a)≠sign(b).
  - remainder negated if a<0.
  - This gives truncation toward zero, and the remainder takes the dividend's sign.
- DONE (1 cycle):
  - done=1 and busy=1.
  - hi/lo are updated on entry to DONE and hold until the next DONE or reset.
  - Next state is IDLE.
- Latency, counted from the start-accepting edge to the edge that asserts done:
  - multiply: W/2+1 cycles (17 at W=32).
  - divide: W+2 cycles (34).
  - divide by zero: 1 cycle.
- Divide by zero: hi=a, lo=all ones, div_by_zero=1. div_by_zero is 0 for all other ops.
- Overflow case MIN_INT / -1: lo=MIN_INT, hi=0, div_by_zero=0. No trap.
- start while busy (MUL/DIV/FIX/DONE): ignored. Not queued; no effect on the operation in flight.
- start in the same cycle the block returns to IDLE: accepted at the next edge only if still asserted. Back-to-back operations therefore have one IDLE cycle between them.
- Operand inputs a, b and op may change freely after the accepting edge; the latched copies are used.
- Reset during MUL/DIV/FIX: the operation is aborted; the block is in IDLE with hi=lo=0 immediately. No done pulse is produced.
- All arithmetic is modulo 2^(2W) internally. No saturation.

Test Plan:
- Multiply 7 × -3 (a=0x00000007, b=0xFFFFFFFD): done exactly 17 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 17 cycles.
- Multiply 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. Multiply 0xFFFFFFFF × 0xFFFFFFFF → hi=0x00000000, lo=0x00000001.
- Divide -17 / 5 (a=0xFFFFFFEF, b=0x00000005): done 34 cycles after accept; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). Divide 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide 0x1234 / 0: done 1 cycle after accept; hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1. A following multiply 2×3 gives div_by_zero=0, lo=6, hi=0.
- Start held high continuously with a multiply followed by a divide: the second start is ignored during busy and accepted on the IDLE cycle. Two done pulses are separated by exactly one non-busy cycle, and hi/lo match each operation.
- Reset asserted 5 cycles into a divide (asynchronously, mid-cycle): busy, done, hi and lo drop to 0 immediately with no done pulse. After release, a new multiply 100×100 returns lo=0x00002710.
